// File: rtl/glitch_sequencer_pkg.sv
// Shared definitions for the glitch pattern sequencer: opcodes, instruction
// field widths and FSM state encodings.
package glitch_sequencer_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_OUT  = 3'd0;
  localparam logic [OP_W-1:0] OP_JMP  = 3'd1;
  localparam logic [OP_W-1:0] OP_LOOP = 3'd2;
  localparam logic [OP_W-1:0] OP_WAIT = 3'd3;
  localparam logic [OP_W-1:0] OP_HALT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_DELAY     = 3'd3,
    S_WAIT_TRIG = 3'd4,
    S_HALTED    = 3'd5
  } state_e;

  // Opcodes above HALT halt the sequencer and flag an error.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_HALT;
  endfunction

endpackage

// File: rtl/glitch_sequencer_if.sv
// Control, program ROM and pattern-output bundle of the glitch sequencer.
interface glitch_sequencer_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DELAY_W = 32
);

  localparam int unsigned INSTR_W = glitch_sequencer_pkg::OP_W + DATA_W + DELAY_W;

  logic               start;
  logic               trig;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [DATA_W-1:0]  parallel_out;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    input  start, trig, rom_data,
    output rom_addr, parallel_out, busy, done, err
  );

  modport slave (
    output start, trig, rom_data,
    input  rom_addr, parallel_out, busy, done, err
  );

endinterface

// File: rtl/glitch_sequencer_tick_prescaler.sv
// Single-cycle tick every PRESCALE clocks; clr restarts the period so the
// first tick after clr lands exactly PRESCALE cycles later.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (clr || (cnt == LAST)) begin
      cnt_nxt = '0;
    end
  end

  // tick is registered and coincides with the cycle in which cnt sits at LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/glitch_sequencer.sv
// Pattern sequencer: fetches instructions from a synchronous ROM, drives a
// registered parallel pattern and times each step in prescaled ticks.
module glitch_sequencer
  import glitch_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DELAY_W  = 32,
  parameter int unsigned PRESCALE = 100
) (
  input  logic               clk,
  input  logic               reset,
  glitch_sequencer_if.master bus
);

  localparam int unsigned DELAY_LSB = 0;
  localparam int unsigned DATA_LSB  = DELAY_W;
  localparam int unsigned OP_LSB    = DELAY_W + DATA_W;

  state_e             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [DATA_W-1:0]  out_q, out_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic               err_q, err_nxt;
  logic [DELAY_W-1:0] dcnt, dcnt_nxt;
  logic [DELAY_W-1:0] loop_cnt, loop_cnt_nxt;
  logic               loop_active, loop_active_nxt;

  logic [OP_W-1:0]    op_c;
  logic [DATA_W-1:0]  data_c;
  logic [DELAY_W-1:0] delay_c;
  logic [ADDR_W-1:0]  target_c;
  logic [DELAY_W-1:0] loop_cur_c;
  logic               presc_clr_c;
  logic               tick;

  assign op_c     = bus.rom_data[OP_LSB +: OP_W];
  assign data_c   = bus.rom_data[DATA_LSB +: DATA_W];
  assign delay_c  = bus.rom_data[DELAY_LSB +: DELAY_W];
  assign target_c = ADDR_W'(data_c);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr_c),
    .tick  (tick)
  );

  // Next-state and datapath update.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    out_nxt         = out_q;
    busy_nxt        = busy_q;
    done_nxt        = done_q;
    err_nxt         = err_q;
    dcnt_nxt        = dcnt;
    loop_cnt_nxt    = loop_cnt;
    loop_active_nxt = loop_active;
    presc_clr_c     = 1'b0;
    loop_cur_c      = loop_active ? loop_cnt : delay_c;

    case (state)
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          pc_nxt          = '0;
          done_nxt        = 1'b0;
          err_nxt         = 1'b0;
          busy_nxt        = 1'b1;
          loop_cnt_nxt    = '0;
          loop_active_nxt = 1'b0;
          state_nxt       = S_FETCH;
        end
      end

      S_FETCH: begin
        state_nxt = S_DECODE;
      end

      S_DECODE: begin
        case (op_c)
          OP_OUT: begin
            out_nxt = data_c;
            pc_nxt  = pc + ADDR_W'(1);
            if (delay_c == '0) begin
              state_nxt = S_FETCH;
            end else begin
              dcnt_nxt    = delay_c;
              presc_clr_c = 1'b1;
              state_nxt   = S_DELAY;
            end
          end
          OP_JMP: begin
            pc_nxt    = target_c;
            state_nxt = S_FETCH;
          end
          OP_LOOP: begin
            // First visit latches the count; each later visit consumes one.
            if (loop_cur_c != '0) begin
              loop_cnt_nxt    = loop_cur_c - DELAY_W'(1);
              loop_active_nxt = 1'b1;
              pc_nxt          = target_c;
            end else begin
              loop_cnt_nxt    = '0;
              loop_active_nxt = 1'b0;
              pc_nxt          = pc + ADDR_W'(1);
            end
            state_nxt = S_FETCH;
          end
          OP_WAIT: begin
            pc_nxt    = pc + ADDR_W'(1);
            state_nxt = S_WAIT_TRIG;
          end
          default: begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            err_nxt   = !op_is_legal(op_c);
            state_nxt = S_HALTED;
          end
        endcase
      end

      S_DELAY: begin
        if (tick) begin
          if (dcnt == DELAY_W'(1)) begin
            dcnt_nxt  = '0;
            state_nxt = S_FETCH;
          end else begin
            dcnt_nxt = dcnt - DELAY_W'(1);
          end
        end
      end

      S_WAIT_TRIG: begin
        if (bus.trig) begin
          state_nxt = S_FETCH;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dcnt        <= '0;
      loop_cnt    <= '0;
      loop_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      out_q       <= out_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      err_q       <= err_nxt;
      dcnt        <= dcnt_nxt;
      loop_cnt    <= loop_cnt_nxt;
      loop_active <= loop_active_nxt;
    end
  end

  // The pc register addresses the ROM directly, so fetch needs no extra stage.
  assign bus.rom_addr     = pc;
  assign bus.parallel_out = out_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer with a synchronous program ROM model.
module tb_glitch_sequencer;
  import glitch_sequencer_pkg::*;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DELAY_W  = 8;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned INSTR_W  = 3 + DATA_W + DELAY_W;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  logic [INSTR_W-1:0] rom [16];

  glitch_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DELAY_W(DELAY_W)) bus ();

  glitch_sequencer #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DELAY_W  (DELAY_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  function automatic logic [INSTR_W-1:0] ins(input logic [2:0] op, input logic [7:0] data,
                                             input logic [7:0] dly);
    return {op, data, dly};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = ins(OP_HALT, 8'h00, 8'h00);
  endtask

  // start high during cycle 0; returns positioned in cycle 1
  task automatic kick();
    bus.start = 1'b1;
    cyc = 0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic load_timing_prog();
    clear_rom();
    rom[0] = ins(OP_OUT, 8'hA5, 8'd3);
    rom[1] = ins(OP_OUT, 8'h3C, 8'd0);
    rom[2] = ins(OP_HALT, 8'h00, 8'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.trig = 1'b0;
    step();
    reset = 1'b0;
    checks++;
    if (bus.parallel_out !== 8'h00) begin
      errors++; $display("FAIL reset_out: got %h want 00", bus.parallel_out);
    end
    checks++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.err});
    end
    checks++;
    if (bus.rom_addr !== 4'd0) begin
      errors++; $display("FAIL reset_addr: got %0d want 0", bus.rom_addr);
    end
  endtask

  task automatic test_timing();
    logic [7:0] exp_out;
    logic       exp_done;
    load_timing_prog();
    kick();
    for (int c = 1; c <= 22; c++) begin
      exp_out  = (c < 3) ? 8'h00 : (c < 17) ? 8'hA5 : 8'h3C;
      exp_done = (c >= 19);
      checks++;
      if (bus.parallel_out !== exp_out) begin
        errors++; $display("FAIL timing_out c%0d: got %h want %h", c, bus.parallel_out, exp_out);
      end
      checks++;
      if ({bus.busy, bus.done} !== {!exp_done, exp_done}) begin
        errors++; $display("FAIL timing_flags c%0d: busy/done got %b want %b", c,
                           {bus.busy, bus.done}, {!exp_done, exp_done});
      end
      step();
    end
  endtask

  task automatic test_loop();
    int   edges;
    logic prev;
    bit   finished;
    clear_rom();
    rom[0] = ins(OP_OUT, 8'h01, 8'd0);
    rom[1] = ins(OP_OUT, 8'h00, 8'd0);
    rom[2] = ins(OP_LOOP, 8'h00, 8'd2);
    rom[3] = ins(OP_HALT, 8'h00, 8'd0);
    for (int run = 0; run < 2; run++) begin
      kick();
      edges = 0;
      prev = bus.parallel_out[0];
      finished = 1'b0;
      for (int c = 0; c < 200 && !finished; c++) begin
        if (bus.parallel_out[0] && !prev) edges++;
        prev = bus.parallel_out[0];
        if (bus.done) finished = 1'b1;
        else step();
      end
      checks++;
      if (!finished) begin
        errors++; $display("FAIL loop_timeout run%0d: done got 0 want 1", run);
      end
      checks++;
      if (edges != 3) begin
        errors++; $display("FAIL loop_edges run%0d: got %0d want 3", run, edges);
      end
      checks++;
      if (bus.err !== 1'b0) begin
        errors++; $display("FAIL loop_err run%0d: got %b want 0", run, bus.err);
      end
    end
  endtask

  task automatic test_trigger();
    bit finished;
    clear_rom();
    rom[0] = ins(OP_OUT, 8'hFF, 8'd0);
    rom[1] = ins(OP_WAIT, 8'h00, 8'd0);
    rom[2] = ins(OP_OUT, 8'h00, 8'd0);
    rom[3] = ins(OP_HALT, 8'h00, 8'd0);
    bus.trig = 1'b0;
    kick();
    while (cyc < 40) begin
      if (cyc >= 5) begin
        checks++;
        if ({bus.parallel_out, bus.busy} !== {8'hFF, 1'b1}) begin
          errors++; $display("FAIL trig_hold c%0d: out/busy got %h/%b want ff/1", cyc,
                             bus.parallel_out, bus.busy);
        end
      end
      step();
    end
    bus.trig = 1'b1;
    step();
    bus.trig = 1'b0;
    checks++;
    if (bus.rom_addr !== 4'd2) begin
      errors++; $display("FAIL trig_addr c41: got %0d want 2", bus.rom_addr);
    end
    step();
    checks++;
    if (bus.parallel_out !== 8'hFF) begin
      errors++; $display("FAIL trig_out c42: got %h want ff", bus.parallel_out);
    end
    step();
    checks++;
    if (bus.parallel_out !== 8'h00) begin
      errors++; $display("FAIL trig_out c43: got %h want 00", bus.parallel_out);
    end
    finished = 1'b0;
    for (int c = 0; c < 20 && !finished; c++) begin
      if (bus.done) finished = 1'b1;
      else step();
    end
    checks++;
    if (!finished) begin
      errors++; $display("FAIL trig_done: done got 0 want 1");
    end
  endtask

  task automatic test_robustness();
    load_timing_prog();
    kick();
    while (cyc < 20) begin
      bus.start = (cyc == 5 || cyc == 8);
      if (cyc == 6 || cyc == 9) begin
        checks++;
        if ({bus.rom_addr, bus.parallel_out} !== {4'd1, 8'hA5}) begin
          errors++; $display("FAIL start_ignored c%0d: addr/out got %0d/%h want 1/a5", cyc,
                             bus.rom_addr, bus.parallel_out);
        end
      end
      if (cyc == 17) begin
        checks++;
        if ({bus.parallel_out, bus.busy} !== {8'h3C, 1'b1}) begin
          errors++; $display("FAIL start_ignored_out c17: out/busy got %h/%b want 3c/1",
                             bus.parallel_out, bus.busy);
        end
      end
      step();
    end
    bus.start = 1'b0;
    checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      errors++; $display("FAIL start_ignored_done: done/busy got %b want 10", {bus.done, bus.busy});
    end
    // reset asserted during cycle 8 of the held A5 pattern
    kick();
    while (cyc < 8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.parallel_out, bus.rom_addr, bus.busy, bus.done, bus.err} !== 15'd0) begin
      errors++; $display("FAIL midreset: out/addr/busy/done/err got %h/%0d/%b%b%b want 00/0/000",
                         bus.parallel_out, bus.rom_addr, bus.busy, bus.done, bus.err);
    end
    step(); step(); step();
    checks++;
    if ({bus.parallel_out, bus.busy} !== 9'd0) begin
      errors++; $display("FAIL midreset_idle: out/busy got %h/%b want 00/0",
                         bus.parallel_out, bus.busy);
    end
  endtask

  task automatic test_illegal();
    bit finished;
    clear_rom();
    for (int i = 0; i < 15; i++) rom[i] = ins(OP_OUT, 8'(i), 8'd0);
    rom[15] = ins(3'd6, 8'h00, 8'd0);
    kick();
    finished = 1'b0;
    for (int c = 0; c < 100 && !finished; c++) begin
      if (bus.done) finished = 1'b1;
      else step();
    end
    checks++;
    if (!finished) begin
      errors++; $display("FAIL illegal_timeout: done got 0 want 1");
    end
    checks++;
    if ({bus.done, bus.err, bus.busy} !== 3'b110) begin
      errors++; $display("FAIL illegal_flags: done/err/busy got %b want 110",
                         {bus.done, bus.err, bus.busy});
    end
    checks++;
    if (bus.parallel_out !== 8'h0E) begin
      errors++; $display("FAIL illegal_out: got %h want 0e", bus.parallel_out);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    for (int i = 0; i < 16; i++) rom[i] = ins(OP_OUT, 8'(i), 8'd0);
    kick();
    checks++;
    if ({bus.err, bus.done, bus.busy} !== 3'b001) begin
      errors++; $display("FAIL wrap_start_flags: err/done/busy got %b want 001",
                         {bus.err, bus.done, bus.busy});
    end
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (bus.rom_addr == 4'd15) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL wrap_reach15: rom_addr got %0d want 15", bus.rom_addr);
    end
    for (int c = 0; c < 4 && bus.rom_addr == 4'd15; c++) step();
    checks++;
    if ({bus.rom_addr, bus.parallel_out, bus.busy} !== {4'd0, 8'h0F, 1'b1}) begin
      errors++; $display("FAIL wrap_addr: addr/out/busy got %0d/%h/%b want 0/0f/1",
                         bus.rom_addr, bus.parallel_out, bus.busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.trig = 1'b0;
    clear_rom();
    test_reset();
    test_timing();
    test_loop();
    test_trigger();
    test_robustness();
    test_illegal();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
